// File: rtl/vmac_pkg.sv
// rtl/vmac_pkg.sv - shared constants and types for the vector MAC result writer
package vmac_pkg;

  localparam int VECTOR  = 16;
  localparam int I_WIDTH = 32;
  localparam int VLEN    = VECTOR * I_WIDTH;
  localparam int ADDR_W  = 7;
  localparam int DEPTH   = 2 ** ADDR_W;
  localparam int LAT     = 3;

  localparam logic [ADDR_W:0] DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
  } tag_t;

  // Requests beyond the memory depth are clamped so the index never wraps.
  function automatic logic [ADDR_W:0] clamp_count(input logic [ADDR_W:0] n);
    if (n > DEPTH_CNT) begin
      return DEPTH_CNT;
    end
    return n;
  endfunction

endpackage

// File: rtl/vmac_tag_delay.sv
// rtl/vmac_tag_delay.sv - fixed-latency shift register carrying read tags to the write port
module vmac_tag_delay
  import vmac_pkg::*;
#(
  parameter int STAGES = LAT
) (
  input  logic clk,
  input  logic reset,
  input  tag_t tag_in,
  output tag_t tag_out,
  output logic pending
);

  tag_t stage_q [STAGES];
  tag_t stage_d [STAGES];

  always_comb begin
    stage_d[0] = tag_in;
    for (int i = 1; i < STAGES; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  // The final stage is excluded: its write retires in the current cycle.
  always_comb begin
    pending = 1'b0;
    for (int i = 0; i < STAGES - 1; i++) begin
      pending = pending | stage_q[i].valid;
    end
  end

  assign tag_out = stage_q[STAGES-1];

endmodule

// File: rtl/vmac_result_writer.sv
// rtl/vmac_result_writer.sv - operand address sequencer and result write-back for the vector MAC
// Optional running XOR of written data on port checksum when VMAC_WR_CHECKSUM_EN is defined.
module vmac_result_writer
  import vmac_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   num_vec,
  input  logic              hold,
  input  logic [VLEN-1:0]   res_vec,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [VLEN-1:0]   wr_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   wr_count
`ifdef VMAC_WR_CHECKSUM_EN
  ,
  output logic [VLEN-1:0]   checksum
`endif
);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_ISSUE = ST_ISSUE;
  localparam logic [1:0] S_DRAIN = ST_DRAIN;
  localparam logic [1:0] S_DONE  = ST_DONE;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W:0]   n_q, n_d;
  logic [ADDR_W:0]   idx_q, idx_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              done_q, done_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;

  logic            accept;
  logic            last_issue;
  logic [ADDR_W:0] n_req;
  tag_t            tag_in;
  tag_t            tail;
  logic            pending;

  assign n_req      = clamp_count(num_vec);
  assign last_issue = (idx_q == (n_q - 1'b1));
  // DONE lasts one cycle and already behaves like IDLE for a new start.
  assign accept     = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign tag_in     = '{valid: rd_en_q, addr: rd_addr_q};

  vmac_tag_delay #(
    .STAGES (LAT)
  ) u_tag_delay (
    .clk     (clk),
    .reset   (reset),
    .tag_in  (tag_in),
    .tag_out (tail),
    .pending (pending)
  );

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    idx_d     = idx_q;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    done_d    = done_q;
    cnt_d     = cnt_q;

    if (tail.valid && (cnt_q != DEPTH_CNT)) begin
      cnt_d = cnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (accept) begin
          n_d     = n_req;
          idx_d   = '0;
          done_d  = 1'b0;
          cnt_d   = '0;
          // An empty run passes through DRAIN, which exits immediately.
          state_d = (n_req == '0) ? S_DRAIN : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!hold) begin
          rd_en_d   = 1'b1;
          rd_addr_d = idx_q[ADDR_W-1:0];
          idx_d     = idx_q + 1'b1;
          if (last_issue) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (!rd_en_q && !pending) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      n_q       <= '0;
      idx_q     <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      done_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      idx_q     <= idx_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      done_q    <= done_d;
      cnt_q     <= cnt_d;
    end
  end

`ifdef VMAC_WR_CHECKSUM_EN
  logic [VLEN-1:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (accept) begin
      csum_d = '0;
    end else if (tail.valid) begin
      csum_d = csum_q ^ res_vec;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign checksum = csum_q;
`endif

  assign rd_en    = rd_en_q;
  assign rd_addr  = rd_addr_q;
  assign wr_en    = tail.valid;
  assign wr_addr  = tail.addr;
  assign wr_data  = tail.valid ? res_vec : '0;
  assign busy     = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign done     = done_q;
  assign wr_count = cnt_q;

endmodule

// File: tb/tb_vmac_result_writer.sv
// tb/tb_vmac_result_writer.sv - table-driven and randomized checks of the result writer
module tb_vmac_result_writer;
  import vmac_pkg::*;

  localparam int MAXC = 600;

  typedef struct {
    int          n;
    logic [31:0] hmask;
    bit          bstart;
    int          exp_done;
    int          exp_cnt;
  } vec_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W:0]   num_vec;
  logic              hold;
  logic [VLEN-1:0]   res_vec;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [VLEN-1:0]   wr_data;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   wr_count;
`ifdef VMAC_WR_CHECKSUM_EN
  logic [VLEN-1:0]   checksum;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  bit m_rd [MAXC];
  int m_ra [MAXC];
  bit m_wr [MAXC];
  int m_wa [MAXC];
  bit m_hold [MAXC];
  int m_done;
  int m_n;

  vmac_result_writer dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .num_vec  (num_vec),
    .hold     (hold),
    .res_vec  (res_vec),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .done     (done),
    .wr_count (wr_count)
`ifdef VMAC_WR_CHECKSUM_EN
    ,
    .checksum (checksum)
`endif
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input int c, input logic [VLEN-1:0] got,
                              input logic [VLEN-1:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s at %0d: got %0h expected %0h", name, c, got, exp);
    end
  endfunction

  function automatic logic [VLEN-1:0] rand_vec();
    logic [VLEN-1:0] v;
    for (int i = 0; i < VECTOR; i++) begin
      v[i*I_WIDTH +: I_WIDTH] = I_WIDTH'($urandom);
    end
    return v;
  endfunction

  function automatic logic [VLEN-1:0] pat(input int addr, input logic [15:0] salt);
    logic [VLEN-1:0] v;
    for (int i = 0; i < VECTOR; i++) begin
      v[i*I_WIDTH +: I_WIDTH] = {salt, 8'(addr), 8'(i)};
    end
    return v;
  endfunction

  // Reference: cycle c counts edges after the accepting edge; a read seen in
  // cycle c needs hold low in cycle c-1 and is written back in cycle c+LAT.
  task automatic build_model(input int n_in, input bit rand_hold, input logic [31:0] hmask);
    int issued;
    int last;
    m_n = (n_in > DEPTH) ? DEPTH : n_in;
    for (int c = 0; c < MAXC; c++) begin
      m_rd[c] = 1'b0;
      m_ra[c] = 0;
      m_wr[c] = 1'b0;
      m_wa[c] = 0;
      m_hold[c] = rand_hold ? ($urandom_range(0, 3) == 0) : ((c < 32) ? hmask[c] : 1'b0);
    end
    issued = 0;
    last   = 0;
    for (int c = 1; c < MAXC - LAT; c++) begin
      if (issued < m_n && !m_hold[c-1]) begin
        m_rd[c] = 1'b1;
        m_ra[c] = issued;
        m_wr[c+LAT] = 1'b1;
        m_wa[c+LAT] = issued;
        issued++;
        last = c;
      end
    end
    m_done = (m_n == 0) ? 1 : last + LAT + 1;
  endtask

  task automatic do_run(input int n_in, input bit rand_hold, input logic [31:0] hmask,
                        input bit busy_start, output int done_at, output int cnt_at_done);
    logic [15:0]     salt;
    logic [VLEN-1:0] wd;
    logic [VLEN-1:0] csum;
    int              cnt;
    salt = 16'($urandom);
    build_model(n_in, rand_hold, hmask);
    done_at     = -1;
    cnt_at_done = -1;
    cnt         = 0;
    csum        = '0;
    @(posedge clk); #1;
    start   = 1'b1;
    num_vec = (ADDR_W+1)'(n_in);
    hold    = 1'b0;
    @(posedge clk); #1;
    for (int c = 0; c <= m_done + 1; c++) begin
      start = busy_start && (c < m_done - 1);
      if (busy_start) num_vec = (ADDR_W+1)'($urandom_range(1, 255));
      hold    = m_hold[c];
      wd      = m_wr[c] ? pat(m_wa[c], salt) : '0;
      res_vec = m_wr[c] ? wd : rand_vec();
      @(negedge clk);
      chk("rd_en", c, VLEN'(rd_en), VLEN'(m_rd[c]));
      if (m_rd[c]) chk("rd_addr", c, VLEN'(rd_addr), VLEN'(m_ra[c]));
      chk("wr_en", c, VLEN'(wr_en), VLEN'(m_wr[c]));
      if (m_wr[c]) chk("wr_addr", c, VLEN'(wr_addr), VLEN'(m_wa[c]));
      chk("wr_data", c, wr_data, wd);
      chk("busy", c, VLEN'(busy), VLEN'(c < m_done));
      chk("done", c, VLEN'(done), VLEN'(c >= m_done));
      chk("wr_count", c, VLEN'(wr_count), VLEN'(cnt));
      if (done === 1'b1 && done_at < 0) begin
        done_at     = c;
        cnt_at_done = int'(wr_count);
      end
      if (m_wr[c]) begin
        cnt++;
        csum = csum ^ wd;
      end
      @(posedge clk); #1;
    end
`ifdef VMAC_WR_CHECKSUM_EN
    chk("checksum", m_done, checksum, csum);
`endif
    start = 1'b0;
  endtask

  vec_t tbl [7];

  initial begin
    int done_at;
    int cnt_at;
    int n;

    tbl[0] = '{n: 4,   hmask: 32'h0, bstart: 1'b0, exp_done: 8,   exp_cnt: 4};
    tbl[1] = '{n: 0,   hmask: 32'h0, bstart: 1'b0, exp_done: 1,   exp_cnt: 0};
    tbl[2] = '{n: 6,   hmask: 32'h6, bstart: 1'b0, exp_done: 12,  exp_cnt: 6};
    tbl[3] = '{n: 1,   hmask: 32'h0, bstart: 1'b0, exp_done: 5,   exp_cnt: 1};
    tbl[4] = '{n: 128, hmask: 32'h0, bstart: 1'b1, exp_done: 132, exp_cnt: 128};
    tbl[5] = '{n: 200, hmask: 32'h0, bstart: 1'b0, exp_done: 132, exp_cnt: 128};
    tbl[6] = '{n: 3,   hmask: 32'h1, bstart: 1'b0, exp_done: 8,   exp_cnt: 3};

    reset   = 1'b1;
    start   = 1'b0;
    hold    = 1'b0;
    num_vec = '0;
    res_vec = rand_vec();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ctrl", 0, VLEN'({rd_en, rd_addr, wr_en, wr_addr, busy, done, wr_count}), '0);
    chk("reset_wr_data", 0, wr_data, '0);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      do_run(tbl[i].n, 1'b0, tbl[i].hmask, tbl[i].bstart, done_at, cnt_at);
      chk("tbl_done_cycle", i, VLEN'(done_at), VLEN'(tbl[i].exp_done));
      chk("tbl_count", i, VLEN'(cnt_at), VLEN'(tbl[i].exp_cnt));
    end

    for (int r = 0; r < 6; r++) begin
      n = ($urandom_range(0, 3) == 0) ? $urandom_range(100, 255) : $urandom_range(0, 20);
      do_run(n, 1'b1, 32'h0, 1'($urandom_range(0, 1)), done_at, cnt_at);
      chk("rand_count", r, VLEN'(cnt_at), VLEN'((n > DEPTH) ? DEPTH : n));
    end

    // Reset one cycle after the second write of a ten-vector run.
    @(posedge clk); #1;
    start   = 1'b1;
    num_vec = (ADDR_W+1)'(10);
    hold    = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 7; c++) begin
      res_vec = rand_vec();
      if (c == 6) reset = 1'b1;
      @(negedge clk);
      chk("pre_rst_wr_en", c, VLEN'(wr_en), VLEN'(c >= 4));
      @(posedge clk); #1;
    end
    reset = 1'b0;
    for (int c = 7; c < 20; c++) begin
      res_vec = rand_vec();
      @(negedge clk);
      if (c == 7) begin
        chk("rst_ctrl", c, VLEN'({rd_en, rd_addr, wr_en, wr_addr, busy, done, wr_count}), '0);
      end
      chk("rst_no_wr", c, VLEN'(wr_en), '0);
      chk("rst_wr_data", c, wr_data, '0);
      chk("rst_idle", c, VLEN'(busy), '0);
      @(posedge clk); #1;
    end
    do_run(2, 1'b0, 32'h0, 1'b0, done_at, cnt_at);
    chk("post_rst_done_cycle", 0, VLEN'(done_at), VLEN'(6));
    chk("post_rst_count", 0, VLEN'(cnt_at), VLEN'(2));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
